counter_ctrl: RTL and testbench

Round-robin controller that shares one loadable up-counter (data/load/enable/count interface, active-low async counter reset driven elsewhere) between `REQ_N` requesters. A granted requester supplies a start value and a limit. The controller loads the start value, enables counting until the count equals the limit, then pulses `done` to that requester. It sits directly in front of the counter and is the only agent driving the counter's `data`, `load` and `enable` inputs.

---
 rtl/counter_ctrl_if.sv | 28 ++
 rtl/counter_ctrl.sv | 166 ++++++++++++++++
 tb/tb_counter_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_if.sv
// Requester and counter-side signal bundle for counter_ctrl.
// slave: the controller; master: requesters plus the attached counter.
interface counter_ctrl_if #(
  parameter int WIDTH = 5,
  parameter int REQ_N = 4
) ();
  logic [REQ_N-1:0]       req;
  logic [REQ_N*WIDTH-1:0] req_start;
  logic [REQ_N*WIDTH-1:0] req_limit;
  logic [REQ_N-1:0]       gnt;
  logic [REQ_N-1:0]       done;
  logic                   abort;
  logic                   busy;
  logic [WIDTH-1:0]       cnt_data;
  logic                   cnt_load;
  logic                   cnt_enable;
  logic [WIDTH-1:0]       cnt_count;

  modport slave (
    input  req, req_start, req_limit, cnt_count,
    output gnt, done, abort, busy, cnt_data, cnt_load, cnt_enable
  );

  modport master (
    output req, req_start, req_limit, cnt_count,
    input  gnt, done, abort, busy, cnt_data, cnt_load, cnt_enable
  );
endinterface

// File: rtl/counter_ctrl.sv
// Round-robin controller sharing one loadable up-counter between REQ_N requesters.
// Optional COUNTER_CTRL_ABORT_EN: a requester dropping req during LOAD/RUN aborts its job.
module counter_ctrl #(
  parameter int WIDTH = 5,
  parameter int REQ_N = 4
) (
  input  logic           clk,
  input  logic           reset,
  counter_ctrl_if.slave  bus
);
  localparam int PW = (REQ_N > 1) ? $clog2(REQ_N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  logic [PW-1:0]    ptr_r;
  logic [PW-1:0]    gidx_r;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] limit_q;
  logic [REQ_N-1:0] gnt_r;
  logic [REQ_N-1:0] done_r;
  logic             abort_r;
  logic             busy_r;
  logic             cnt_load_r;
  logic             cnt_enable_s;
  logic             pick_found_s;
  logic [PW-1:0]    pick_idx_s;
  logic             drop_s;
  logic             at_limit_s;

  function automatic logic [REQ_N-1:0] onehot(input logic [PW-1:0] idx);
    logic [REQ_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    logic [PW-1:0] n;
    if (idx == PW'(REQ_N - 1)) n = '0;
    else                       n = idx + 1'b1;
    return n;
  endfunction

  // Walk offsets from farthest to nearest so the first set bit at/after base wins.
  function automatic logic [PW:0] rr_pick(input logic [REQ_N-1:0] r, input logic [PW-1:0] base);
    logic [PW:0] res;
    int          j;
    res = '0;
    for (int off = REQ_N - 1; off >= 0; off--) begin
      j = int'(base) + off;
      j = (j >= REQ_N) ? (j - REQ_N) : j;
      if (r[j]) res = {1'b1, PW'(j)};
      else      res = res;
    end
    return res;
  endfunction

  // Round-robin candidate for the next grant.
  always_comb begin
    {pick_found_s, pick_idx_s} = rr_pick(bus.req, ptr_r);
  end

  // Job-abandon condition for the granted requester, plus the limit compare.
  always_comb begin
`ifdef COUNTER_CTRL_ABORT_EN
    drop_s = ~bus.req[gidx_r];
`else
    drop_s = 1'b0;
`endif
    at_limit_s = (bus.cnt_count == limit_q);
  end

  // Counter enable is combinational so the counter stops on the exact cycle it reaches limit.
  always_comb begin
    cnt_enable_s = 1'b0;
    if (state_r == RUN) begin
      cnt_enable_s = ~drop_s & ~at_limit_s;
    end else begin
      cnt_enable_s = 1'b0;
    end
  end

  // Arbitration, job sequencing and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      ptr_r      <= '0;
      gidx_r     <= '0;
      start_q    <= '0;
      limit_q    <= '0;
      gnt_r      <= '0;
      done_r     <= '0;
      abort_r    <= 1'b0;
      busy_r     <= 1'b0;
      cnt_load_r <= 1'b0;
    end else begin
      done_r  <= '0;
      abort_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            state_r    <= LOAD;
            gidx_r     <= pick_idx_s;
            ptr_r      <= next_idx(pick_idx_s);
            start_q    <= bus.req_start[pick_idx_s*WIDTH +: WIDTH];
            limit_q    <= bus.req_limit[pick_idx_s*WIDTH +: WIDTH];
            gnt_r      <= onehot(pick_idx_s);
            busy_r     <= 1'b1;
            cnt_load_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          cnt_load_r <= 1'b0;
          if (drop_s) begin
            state_r <= IDLE;
            gnt_r   <= '0;
            busy_r  <= 1'b0;
            abort_r <= 1'b1;
          end else begin
            state_r <= RUN;
          end
        end
        RUN: begin
          if (drop_s) begin
            state_r <= IDLE;
            gnt_r   <= '0;
            busy_r  <= 1'b0;
            abort_r <= 1'b1;
          end else if (at_limit_s) begin
            state_r <= DONE;
            done_r  <= onehot(gidx_r);
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          state_r <= IDLE;
          gnt_r   <= '0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          gnt_r      <= '0;
          busy_r     <= 1'b0;
          cnt_load_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_r;
  assign bus.done       = done_r;
  assign bus.abort      = abort_r;
  assign bus.busy       = busy_r;
  assign bus.cnt_data   = start_q;
  assign bus.cnt_load   = cnt_load_r;
  assign bus.cnt_enable = cnt_enable_s;
endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl with a behavioural loadable up-counter attached.
module tb_counter_ctrl;
  localparam int W = 5;
  localparam int N = 4;
  localparam int K_GNT = 0, K_DONE = 1, K_ABORT = 2;

  typedef struct {
    int           kind;
    logic [N-1:0] val;
    int           cyc;
    logic [W-1:0] cnt;
    int           en;
  } ev_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         cnt_rst_n;
  logic [W-1:0] count_q;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           en_seen = 0;
  logic [N-1:0] prev_gnt = '0;
  ev_t          sb[$];

  counter_ctrl_if #(.WIDTH(W), .REQ_N(N)) bus ();

  counter_ctrl #(.WIDTH(W), .REQ_N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) cyc <= cyc + 1;

  // Attached counter: async active-low reset, load has priority over enable.
  always_ff @(posedge clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n)         count_q <= '0;
    else if (bus.cnt_load)  count_q <= bus.cnt_data;
    else if (bus.cnt_enable) count_q <= count_q + 1'b1;
  end
  assign bus.cnt_count = count_q;

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [N-1:0] val, input int at, input int cnt, input int en);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = at;
    e.cnt  = W'(cnt);
    e.en   = en;
    sb.push_back(e);
  endtask

  task automatic got(input int kind, input logic [N-1:0] val);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d value %b at cycle %0d, expected none", kind, val, cyc);
    end else begin
      e = sb.pop_front();
      chk("ev_kind", 32'(kind), 32'(e.kind));
      chk("ev_value", 32'(val), 32'(e.val));
      chk("ev_cycle", 32'(cyc), 32'(e.cyc));
      if (kind != K_GNT) begin
        chk("ev_count", 32'(bus.cnt_count), 32'(e.cnt));
        chk("ev_enables", 32'(en_seen), 32'(e.en));
      end
    end
  endtask

  // Monitor: samples settled outputs mid-low-phase and pops the scoreboard on each event.
  always begin
    @(negedge clk);
    #2;
    if (bus.gnt != '0 && prev_gnt == '0) begin
      en_seen = 0;
      got(K_GNT, bus.gnt);
    end
    if (bus.cnt_enable) en_seen++;
    if (bus.done != '0) got(K_DONE, bus.done);
    if (bus.abort)      got(K_ABORT, bus.gnt);
    if (bus.busy) chk("load_and_enable", 32'(bus.cnt_load & bus.cnt_enable), 32'd0);
    prev_gnt = bus.gnt;
  end

  task automatic to_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic set_vals(input int i, input int s, input int l);
    bus.req_start[i*W +: W] = W'(s);
    bus.req_limit[i*W +: W] = W'(l);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_abort", 32'(bus.abort), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_cnt_load", 32'(bus.cnt_load), 32'd0);
    chk("rst_cnt_enable", 32'(bus.cnt_enable), 32'd0);
    chk("rst_cnt_data", 32'(bus.cnt_data), 32'd0);
  endtask

  // Single job from an idle controller with k = (limit - start) mod 2^W increments.
  task automatic job(input int i, input int s, input int l, input int k);
    int c0;
    c0 = cyc;
    set_vals(i, s, l);
    bus.req[i] = 1'b1;
    push(K_GNT, oh(i), c0 + 1, 0, 0);
    push(K_DONE, oh(i), c0 + k + 3, l, k);
    to_cyc(c0 + 1);
    chk("load_pulse", 32'(bus.cnt_load), 32'd1);
    chk("load_data", 32'(bus.cnt_data), 32'(s));
    chk("load_no_enable", 32'(bus.cnt_enable), 32'd0);
    to_cyc(c0 + 2);
    chk("run_busy", 32'(bus.busy), 32'd1);
    chk("run_count_start", 32'(bus.cnt_count), 32'(s));
    chk("run_load_low", 32'(bus.cnt_load), 32'd0);
    to_cyc(c0 + k + 3);
    bus.req[i] = 1'b0;
    to_cyc(c0 + k + 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int c1;
    reset         = 1'b1;
    cnt_rst_n     = 1'b0;
    bus.req       = '0;
    bus.req_start = '0;
    bus.req_limit = '0;
    @(negedge clk);
    cnt_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    reset = 1'b0;

    job(0, 3, 7, 4);
    job(1, 30, 2, 4);
    job(2, 9, 9, 0);

    // Reset in the middle of RUN: no done, counter holds, pointer restarts at 0.
    c0 = cyc;
    set_vals(2, 0, 20);
    bus.req = 4'b0100;
    push(K_GNT, oh(2), c0 + 1, 0, 0);
    to_cyc(c0 + 5);
    reset = 1'b1;
    to_cyc(c0 + 6);
    chk_reset_outputs();
    chk("cnt_after_reset", 32'(bus.cnt_count), 32'd4);
    reset = 1'b0;
    c1 = c0 + 6;
    set_vals(1, 5, 6);
    set_vals(3, 12, 13);
    bus.req = 4'b1010;
    push(K_GNT, oh(1), c1 + 1, 0, 0);
    push(K_DONE, oh(1), c1 + 4, 6, 1);
    to_cyc(c1 + 1);
    chk("cnt_held", 32'(bus.cnt_count), 32'd4);
    to_cyc(c1 + 4);
    bus.req = '0;
    to_cyc(c1 + 5);

    // Plain reset, then round-robin with all requesters held.
    reset = 1'b1;
    to_cyc(cyc + 1);
    chk_reset_outputs();
    reset = 1'b0;
    c0 = cyc;
    for (int i = 0; i < N; i++) set_vals(i, 3 * i, 3 * i + 1);
    bus.req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      push(K_GNT, oh(j % N), c0 + 1 + 5 * j, 0, 0);
      push(K_DONE, oh(j % N), c0 + 4 + 5 * j, 3 * (j % N) + 1, 1);
    end
    to_cyc(c0 + 24);
    bus.req = '0;
    to_cyc(c0 + 25);

    // Requester 2 drops req during RUN while requester 3 waits.
    c0 = cyc;
    set_vals(2, 0, 10);
    set_vals(3, 4, 6);
    bus.req = 4'b1100;
    push(K_GNT, oh(2), c0 + 1, 0, 0);
`ifdef COUNTER_CTRL_ABORT_EN
    push(K_ABORT, '0, c0 + 4, 1, 1);
    push(K_GNT, oh(3), c0 + 5, 0, 0);
    push(K_DONE, oh(3), c0 + 9, 6, 2);
    to_cyc(c0 + 3);
    bus.req[2] = 1'b0;
    #1;
    chk("drop_enable", 32'(bus.cnt_enable), 32'd0);
    to_cyc(c0 + 9);
    bus.req[3] = 1'b0;
    to_cyc(c0 + 10);
`else
    push(K_DONE, oh(2), c0 + 13, 10, 10);
    push(K_GNT, oh(3), c0 + 15, 0, 0);
    push(K_DONE, oh(3), c0 + 19, 6, 2);
    to_cyc(c0 + 3);
    bus.req[2] = 1'b0;
    #1;
    chk("drop_enable", 32'(bus.cnt_enable), 32'd1);
    to_cyc(c0 + 19);
    bus.req[3] = 1'b0;
    to_cyc(c0 + 20);
`endif

    to_cyc(cyc + 4);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("final_idle_busy", 32'(bus.busy), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
